// File: rtl/debounce_sync.sv
// Debounces and synchronizes a bouncy asynchronous 1-bit input into a clean registered level,
// with single-cycle rise/fall pulses and a busy flag while a candidate transition is qualified.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHECK_HI  = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHECK_LO  = 2'd3;

  localparam logic [1:0]       RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  // With a one-sample qualification window the CHECK states are bypassed entirely.
  localparam bit               SINGLE      = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Plain shift chain: nothing may sit between the metastability-hardening flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      STABLE_LO: begin
        if (sync_q) begin
          if (SINGLE) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = CHECK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHECK_HI: begin
        if (!sync_q) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABLE_HI: begin
        if (!sync_q) begin
          if (SINGLE) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = CHECK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end

      CHECK_LO: begin
        if (sync_q) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = level_q ? STABLE_HI : STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= CNT_ZERO;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: a default instance and a corner instance (1-cycle window, 3 sync
// stages, reset high), both compared every cycle against a run-length reference model.
module tb_debounce_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic din_a, rst_a, level_a, rise_a, fall_a, busy_a;
  logic din_b, rst_b, level_b, rise_b, fall_b, busy_b;

  debounce_sync dut_a (
    .clk  (clk),
    .rst  (rst_a),
    .din  (din_a),
    .level(level_a),
    .rise (rise_a),
    .fall (fall_a),
    .busy (busy_a)
  );

  debounce_sync #(
    .SYNC_STAGES  (3),
    .STABLE_CYCLES(1),
    .RESET_LEVEL  (1'b1)
  ) dut_b (
    .clk  (clk),
    .rst  (rst_b),
    .din  (din_b),
    .level(level_b),
    .rise (rise_b),
    .fall (fall_b),
    .busy (busy_b)
  );

  // Reference: a delay line of raw samples plus a count of consecutive mismatching samples.
  typedef struct {
    logic [7:0] pipe;
    logic       level;
    int         run;
    logic       rise;
    logic       fall;
  } model_t;

  model_t ma, mb;
  int checks = 0;
  int errors = 0;

  task automatic model_step(inout model_t m, input logic d, input logic r, input int stages,
                            input int stable, input logic rl);
    logic s;
    m.rise = 1'b0;
    m.fall = 1'b0;
    if (r) begin
      m.pipe  = {8{rl}};
      m.level = rl;
      m.run   = 0;
    end else begin
      s      = m.pipe[stages-1];
      m.pipe = {m.pipe[6:0], d};
      if (s != m.level) begin
        m.run = m.run + 1;
        if (m.run >= stable) begin
          m.level = s;
          m.rise  = s;
          m.fall  = ~s;
          m.run   = 0;
        end
      end else begin
        m.run = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance both models at the edge, then compare all outputs.
  task automatic step(input logic da, input logic ra, input logic db, input logic rb);
    din_a = da;
    rst_a = ra;
    din_b = db;
    rst_b = rb;
    @(posedge clk);
    model_step(ma, da, ra, 2, 4, 1'b0);
    model_step(mb, db, rb, 3, 1, 1'b1);
    #1;
    chk("a_level", level_a, ma.level);
    chk("a_rise", rise_a, ma.rise);
    chk("a_fall", fall_a, ma.fall);
    chk("a_busy", busy_a, ma.run > 0);
    chk("a_rise_fall_excl", rise_a & fall_a, 1'b0);
    chk("b_level", level_b, mb.level);
    chk("b_rise", rise_b, mb.rise);
    chk("b_fall", fall_b, mb.fall);
    chk("b_busy", busy_b, 1'b0);
  endtask

  int   lat;
  int   nrise;
  int   nfall;
  logic d;
  logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    din_a = 1'b0; rst_a = 1'b1; din_b = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Reset both instances for two cycles.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("reset_level_a", level_a, 1'b0);
    chk("reset_level_b", level_b, 1'b1);

    // Clean rise: din first sampled high at E0, rise expected 5 edges later.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!rise_a && lat < 12) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      lat++;
    end
    chk_int("clean_rise_latency", lat, 5);
    chk("clean_rise_level", level_a, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rise_one_cycle", rise_a, 1'b0);

    // Clean fall back to 0.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!fall_a && lat < 12) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      lat++;
    end
    chk_int("clean_fall_latency", lat, 5);
    chk("clean_fall_level", level_a, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Glitch: three high samples are not enough to qualify.
    nrise = 0;
    nfall = 0;
    repeat (3) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      nrise += int'(rise_a);
      nfall += int'(fall_a);
    end
    repeat (8) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      nrise += int'(rise_a);
      nfall += int'(fall_a);
    end
    chk_int("glitch_pulses", nrise + nfall, 0);
    chk("glitch_level", level_a, 1'b0);
    chk("glitch_idle", busy_a, 1'b0);

    // Bounce then settle: exactly one rise in total.
    nrise = 0;
    for (int i = 0; i < 6; i++) begin
      step(pat[i], 1'b0, 1'b1, 1'b0);
      nrise += int'(rise_a);
    end
    repeat (10) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      nrise += int'(rise_a);
    end
    chk_int("bounce_rise_count", nrise, 1);
    chk("bounce_level", level_a, 1'b1);

    // Back to 0, then reset while the counter is at 2.
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("midqual_busy", busy_a, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midqual_level", level_a, 1'b0);
    chk("midqual_busy_clr", busy_a, 1'b0);
    chk("midqual_no_rise", rise_a, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lat = 0;
    while (!rise_a && lat < 12) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      lat++;
    end
    chk_int("midqual_rerise_latency", lat, 5);

    // Corner instance: din_b 1->0 at E0 gives fall at E0+3.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lat = 0;
    while (!fall_b && lat < 12) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      lat++;
    end
    chk_int("corner_fall_latency", lat, 3);
    chk("corner_level", level_b, 1'b0);

    // Toggling every cycle never qualifies on the default instance.
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
    nrise = 0;
    for (int i = 0; i < 40; i++) begin
      step(logic'(i[0]), 1'b0, 1'b0, 1'b0);
      nrise += int'(rise_a);
    end
    chk_int("toggle_no_rise", nrise, 0);

    // Random stimulus with sticky din and occasional resets.
    d = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) d = ~d;
      step(d, $urandom_range(99) == 0, ($urandom_range(2) == 0) ? ~d : d,
           $urandom_range(99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
